// File: rtl/alu_issue_arb.sv
// Round-robin issue arbiter: picks one ready requester per cycle, registers it
// in a single-entry issue stage and hands it to the shared ALU via valid/ready.
module alu_issue_arb #(
    parameter int N   = 4,
    parameter int W   = 96,
    parameter int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_data,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [W-1:0]     issue_data,
    output logic [IDW-1:0]   issue_src,
    output logic [31:0]      issued_cnt
);

    localparam int SW = IDW + 1;
    localparam logic [SW-1:0]  LP_N    = SW'(N);
    localparam logic [IDW-1:0] LP_LAST = IDW'(N - 1);

    logic             r_issue_valid;
    logic [W-1:0]     r_issue_data;
    logic [IDW-1:0]   r_issue_src;
    logic [IDW-1:0]   r_rr_ptr;
    logic [31:0]      r_issued_cnt;

    logic             w_can_accept;
    logic             w_hit;
    logic             w_gnt;
    logic [IDW-1:0]   w_gnt_idx;
    logic [IDW-1:0]   w_nxt_ptr;
    logic [N-1:0]     w_ready;
    logic [W-1:0]     w_gnt_data;
    logic             w_handshake;

    // No grant while reset is asserted: the issue register could not capture it.
    assign w_can_accept = rst && !flush && (!r_issue_valid || issue_ready);
    assign w_handshake  = r_issue_valid && issue_ready && !flush;

    always_comb begin
        logic [SW-1:0] sum;
        w_hit     = 1'b0;
        w_gnt_idx = '0;
        sum       = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, r_rr_ptr} + SW'(k);
            if (sum >= LP_N) begin
                sum = sum - LP_N;
            end
            if (!w_hit && req_valid[sum[IDW-1:0]]) begin
                w_hit     = 1'b1;
                w_gnt_idx = sum[IDW-1:0];
            end
        end
    end

    assign w_gnt     = w_hit && w_can_accept;
    assign w_nxt_ptr = (w_gnt_idx == LP_LAST) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_ready    = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt && (w_gnt_idx == IDW'(i))) begin
                w_ready[i] = 1'b1;
                w_gnt_data = req_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_issue_valid <= 1'b0;
            r_issue_data  <= '0;
            r_issue_src   <= '0;
            r_rr_ptr      <= '0;
            r_issued_cnt  <= '0;
        end else begin
            if (flush) begin
                r_issue_valid <= 1'b0;
            end else if (w_gnt) begin
                r_issue_valid <= 1'b1;
                r_issue_data  <= w_gnt_data;
                r_issue_src   <= w_gnt_idx;
                r_rr_ptr      <= w_nxt_ptr;
            end else if (issue_ready) begin
                r_issue_valid <= 1'b0;
            end
            if (w_handshake) begin
                r_issued_cnt <= r_issued_cnt + 32'd1;
            end
        end
    end

    assign req_ready   = w_ready;
    assign issue_valid = r_issue_valid;
    assign issue_data  = r_issue_data;
    assign issue_src   = r_issue_src;
    assign issued_cnt  = r_issued_cnt;

endmodule
